// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, idle sample default and sequencer state encoding.
package audio_pkg;
   localparam int SAMPLE_W = 8;
   localparam logic [SAMPLE_W-1:0] IDLE_SAMPLE_DEF = 8'h00;
   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running sample-period divider, tick on the cycle the count equals period.
module sample_tick_gen #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic [W-1:0] period,
   output logic         tick
);
   logic [W-1:0] cnt;
   assign tick = cnt == period;
   always_ff @(posedge clk)
      if (reset || clr) cnt <= '0;
      else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/audio_latch_sequencer.sv
// audio_latch_sequencer: 2-entry sample FIFO drained into a downstream latch at a programmable rate.
module audio_latch_sequencer import audio_pkg::*; #(
   parameter logic [SAMPLE_W-1:0] IDLE_SAMPLE = IDLE_SAMPLE_DEF,
   parameter int DIV_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [DIV_W-1:0]    div_val,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic [SAMPLE_W-1:0] latch_data,
   output logic                latch_en,
   output logic [7:0]          underrun_cnt,
   output logic                busy
);
   state_t state_q, state_d;
   logic [DIV_W-1:0] period_q;
   logic [SAMPLE_W-1:0] fifo_q [2];
   logic [SAMPLE_W-1:0] fifo_d [2];
   logic [1:0] fill_q;
   logic tick, strobe, push, pop, wr_idx;

   assign sample_ready = fill_q != 2'd2 && !reset;
   assign push = sample_valid && sample_ready;
   assign strobe = state_q == RUN && tick;
   assign pop = strobe && fill_q != 2'd0;
   // slot for the incoming sample after any same-cycle pop has shifted the head out
   assign wr_idx = fill_q[0] ^ pop;

   sample_tick_gen #(.W(DIV_W)) u_tick (
      .clk(clk),
      .reset(reset),
      .clr(state_q != RUN),
      .period(period_q),
      .tick(tick)
   );

   always_ff @(posedge clk)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;

   always_comb
      state_d = !run ? IDLE :
                state_q == IDLE ? ARM :
                (state_q == ARM && fill_q != 2'd0) ? RUN : state_q;

   always_comb
      busy = state_q != IDLE;

   always_ff @(posedge clk)
      if (reset) period_q <= '0;
      else if (state_q == IDLE && run) period_q <= div_val;

   always_comb begin
      fifo_d = fifo_q;
      if (pop) fifo_d[0] = fifo_q[1];
      if (push) fifo_d[wr_idx] = sample_in;
   end

   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
      if (reset) fill_q <= 2'd0;
      else fill_q <= fill_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk)
      if (reset) begin
         latch_en <= 1'b0;
         latch_data <= IDLE_SAMPLE;
         underrun_cnt <= 8'd0;
      end else begin
         latch_en <= strobe;
         if (strobe) latch_data <= pop ? fifo_q[0] : IDLE_SAMPLE;
         if (strobe && !pop && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
      end
endmodule
